// File: rtl/add8_seq_ctrl.sv
// Byte-serial NBYTES-wide add/subtract sequencer that drives an external 8-bit adder.
// Optional signed saturation of the final result is enabled by defining ADD8_SEQ_SAT_EN.
module add8_seq_ctrl #(
   parameter  int NBYTES = 4,
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op_sub,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_flag,
   output logic         overflow_flag,
   output logic         sign_flag,
   output logic         zero_flag,
   output logic [7:0]   add_a,
   output logic [7:0]   add_b,
   output logic         add_cin,
   input  logic [7:0]   add_c,
   input  logic         add_carry_out,
   input  logic         add_overflow
);

   // state     | meaning
   // ST_IDLE   | waiting for start
   // ST_RUN    | one byte through the adder per cycle, LSB first
   // ST_FINISH | single-cycle done pulse; a new start is accepted here

   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [W-1:0]     a_lat_q,    a_lat_d;
   logic [W-1:0]     b_lat_q,    b_lat_d;
   logic             sub_q,      sub_d;
   logic [IDX_W-1:0] idx_q,      idx_d;
   logic             carry_q,    carry_d;
   logic             zero_run_q, zero_run_d;
   logic [W-1:0]     result_q,   result_d;
   logic             cflag_q,    cflag_d;
   logic             vflag_q,    vflag_d;
   logic             sflag_q,    sflag_d;
   logic             zflag_q,    zflag_d;

   logic             accept;
   logic             last_byte;
   logic [7:0]       a_byte;
   logic [7:0]       b_byte;

   assign accept    = start && (state_q != ST_RUN);
   assign last_byte = (idx_q == LAST_IDX);
   assign a_byte    = a_lat_q[int'(idx_q) * 8 +: 8];
   assign b_byte    = b_lat_q[int'(idx_q) * 8 +: 8];

   always_comb begin
      add_a   = 8'h00;
      add_b   = 8'h00;
      add_cin = 1'b0;
      if (state_q == ST_RUN) begin
         add_a   = a_byte;
         add_b   = b_byte ^ {8{sub_q}};
         add_cin = carry_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_lat_d    = a_lat_q;
      b_lat_d    = b_lat_q;
      sub_d      = sub_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      zero_run_d = zero_run_q;
      result_d   = result_q;
      cflag_d    = cflag_q;
      vflag_d    = vflag_q;
      sflag_d    = sflag_q;
      zflag_d    = zflag_q;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            result_d[int'(idx_q) * 8 +: 8] = add_c;
            carry_d    = add_carry_out;
            zero_run_d = zero_run_q && (add_c == 8'h00);
            idx_d      = idx_q + IDX_W'(1);
            if (last_byte) begin
               cflag_d = add_carry_out;
               vflag_d = add_overflow;
               sflag_d = add_c[7];
               zflag_d = zero_run_q && (add_c == 8'h00);
`ifdef ADD8_SEQ_SAT_EN
               // Overflow implies both effective operand signs match a's sign.
               if (add_overflow) begin
                  if (a_lat_q[W-1]) begin
                     result_d = {1'b1, {(W-1){1'b0}}};
                     sflag_d  = 1'b1;
                  end else begin
                     result_d = {1'b0, {(W-1){1'b1}}};
                     sflag_d  = 1'b0;
                  end
                  zflag_d = 1'b0;
               end
`endif
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = start ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Result and flags are left alone here; they get overwritten byte by byte.
      if (accept) begin
         a_lat_d    = op_a;
         b_lat_d    = op_b;
         sub_d      = op_sub;
         idx_d      = '0;
         carry_d    = op_sub;
         zero_run_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         a_lat_q    <= '0;
         b_lat_q    <= '0;
         sub_q      <= 1'b0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         zero_run_q <= 1'b0;
         result_q   <= '0;
         cflag_q    <= 1'b0;
         vflag_q    <= 1'b0;
         sflag_q    <= 1'b0;
         zflag_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_lat_q    <= a_lat_d;
         b_lat_q    <= b_lat_d;
         sub_q      <= sub_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         zero_run_q <= zero_run_d;
         result_q   <= result_d;
         cflag_q    <= cflag_d;
         vflag_q    <= vflag_d;
         sflag_q    <= sflag_d;
         zflag_q    <= zflag_d;
      end
   end

   assign busy          = (state_q == ST_RUN);
   assign done          = (state_q == ST_FINISH);
   assign result        = result_q;
   assign carry_flag    = cflag_q;
   assign overflow_flag = vflag_q;
   assign sign_flag     = sflag_q;
   assign zero_flag     = zflag_q;

endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Directed bench for add8_seq_ctrl (NBYTES=4) with a behavioural 8-bit adder attached.
module tb_add8_seq_ctrl;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_flag;
   logic         overflow_flag;
   logic         sign_flag;
   logic         zero_flag;
   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_cin;
   logic [7:0]   add_c;
   logic         add_carry_out;
   logic         add_overflow;

   int n_checks = 0;
   int n_errors = 0;

   add8_seq_ctrl #(.NBYTES(NB)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .op_sub        (op_sub),
      .op_a          (op_a),
      .op_b          (op_b),
      .busy          (busy),
      .done          (done),
      .result        (result),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag),
      .sign_flag     (sign_flag),
      .zero_flag     (zero_flag),
      .add_a         (add_a),
      .add_b         (add_b),
      .add_cin       (add_cin),
      .add_c         (add_c),
      .add_carry_out (add_carry_out),
      .add_overflow  (add_overflow)
   );

   // External adder stand-in.
   assign {add_carry_out, add_c} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
   assign add_overflow = (add_a[7] == add_b[7]) && (add_c[7] != add_a[7]);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation in the current cycle, walks the RUN cycles and checks the done cycle.
   // Returns in the done cycle so a following call exercises back-to-back acceptance.
   task automatic run_op(input string name, input logic sub, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic [3:0] f,
                         input bit cin_chk, input bit inj);
      op_sub = sub;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int i = 1; i <= NB; i++) begin
         chk({name, " busy/done run"}, 32'({busy, done}), 32'h2);
         if (cin_chk && i >= 2) chk({name, " add_cin"}, 32'(add_cin), 32'h1);
         if (inj && i == 2) begin
            start  = 1'b1;
            op_a   = 32'h1234_5678;
            op_b   = 32'h0F0F_0F0F;
            op_sub = ~sub;
         end else begin
            start  = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      chk({name, " busy/done fin"}, 32'({busy, done}), 32'h1);
      chk({name, " result"}, result, r);
      chk({name, " flags cvsz"}, 32'({carry_flag, overflow_flag, sign_flag, zero_flag}), 32'(f));
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      op_a   = '0;
      op_b   = '0;
      tick();
      tick();
      chk("reset busy/done", 32'({busy, done}), 32'h0);
      chk("reset result", result, 32'h0);
      chk("reset flags", 32'({carry_flag, overflow_flag, sign_flag, zero_flag}), 32'h0);
      chk("reset adder drive", {15'h0, add_cin, add_a, add_b}, 32'h0);
      rst = 1'b0;
      tick();

      run_op("add_ff_1", 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 4'b0000, 1'b0, 1'b0);
      tick();
      chk("idle after done", 32'({busy, done}), 32'h0);
      chk("result hold", result, 32'h0000_0100);

`ifdef ADD8_SEQ_SAT_EN
      run_op("add_pos_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0100, 1'b0, 1'b0);
      tick();
      run_op("sub_neg_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 4'b1110, 1'b0, 1'b0);
`else
      run_op("add_pos_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110, 1'b0, 1'b0);
      tick();
      run_op("sub_neg_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100, 1'b0, 1'b0);
`endif
      tick();
      run_op("sub_5_5", 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1001, 1'b0, 1'b0);
      tick();
      run_op("sub_0_1", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010, 1'b0, 1'b0);
      tick();
      run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001, 1'b1, 1'b0);
      tick();

      // Mid-run start ignored, then a start in the done cycle is taken without a gap.
      run_op("ignore_start", 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 4'b0000, 1'b0, 1'b1);
      run_op("back2back", 1'b1, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0, 4'b0010, 1'b0, 1'b0);
      tick();

      // Reset in cycle 3 of a run.
      op_sub = 1'b0;
      op_a   = 32'h0000_FFFF;
      op_b   = 32'h0000_0001;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      rst    = 1'b1;
      tick();
      rst    = 1'b0;
      chk("abort busy/done", 32'({busy, done}), 32'h0);
      chk("abort result", result, 32'h0);
      chk("abort flags", 32'({carry_flag, overflow_flag, sign_flag, zero_flag}), 32'h0);
      tick();
      chk("abort no done", 32'({busy, done}), 32'h0);
      run_op("post_reset", 1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000, 1'b0, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
